// File: rtl/rv_soc_pkg.sv
// Shared RV_SoC constants: requester owner encoding, default memory geometry and base address.
package rv_soc_pkg;

    localparam logic        OWN_I      = 1'b0;
    localparam logic        OWN_D      = 1'b1;
    localparam int unsigned DEFAULT_AW = 12;
    localparam logic [31:0] MEM_BASE   = 32'h8000_0000;

    // Return tag captured at grant time, consumed one cycle later.
    typedef struct packed {
        logic owner;
        logic err;
        logic valid;
    } ret_tag_t;

endpackage

// File: rtl/rv_mem_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and data load/store; data has priority,
// fetch is guaranteed a grant after MAX_DSTREAK consecutive data grants.
module rv_mem_arbiter
    import rv_soc_pkg::*;
#(
    parameter int unsigned AW          = DEFAULT_AW,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [3:0]    d_be,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          m_en,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata
);

    localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] StreakMax = SW'(MAX_DSTREAK);

    logic [SW-1:0] streak_q, streak_d;
    ret_tag_t      tag_q, tag_d;
    logic [31:0]   i_hold_q, d_hold_q;
    logic          d_oor;
    logic          unused_addr_bits;

    assign d_oor            = |d_addr[31:AW+2];
    assign unused_addr_bits = ^{i_addr[31:AW], d_addr[1:0]};

    // Arbitration and memory drive; reset suppresses every grant.
    always_comb begin
        i_gnt   = 1'b0;
        d_gnt   = 1'b0;
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_be    = 4'h0;
        m_addr  = '0;
        m_wdata = '0;
        if (!rst) begin
            if (d_req && (!i_req || streak_q < StreakMax)) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
        if (i_gnt) begin
            m_en   = 1'b1;
            m_be   = 4'hF;
            m_addr = i_addr[AW-1:0];
        end else if (d_gnt && !d_oor) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr[AW+1:2];
            m_be    = d_we ? d_be : 4'hF;
            m_wdata = d_wdata;
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (!i_req || i_gnt) begin
            streak_d = '0;
        end else if (d_gnt && streak_q < StreakMax) begin
            streak_d = streak_q + SW'(1);
        end
        tag_d.owner = d_gnt ? OWN_D : OWN_I;
        tag_d.err   = d_gnt && d_oor;
        tag_d.valid = i_gnt || d_gnt;
    end

    // A stale tag must not leak out while rst is held, so outputs are gated as well.
    always_comb begin
        i_rvalid = !rst && tag_q.valid && (tag_q.owner == OWN_I);
        d_rvalid = !rst && tag_q.valid && (tag_q.owner == OWN_D);
        d_err    = d_rvalid && tag_q.err;
        i_rdata  = rst ? 32'h0 : (i_rvalid ? m_rdata : i_hold_q);
        d_rdata  = rst ? 32'h0 : (d_rvalid ? (tag_q.err ? 32'h0 : m_rdata) : d_hold_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
            tag_q    <= '0;
            i_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            streak_q <= streak_d;
            tag_q    <= tag_d;
            i_hold_q <= i_rdata;
            d_hold_q <= d_rdata;
        end
    end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Scoreboard bench for rv_mem_arbiter: per-cycle grant/memory-drive checks and queued responses.
module tb_rv_mem_arbiter;
    import rv_soc_pkg::*;

    localparam int unsigned AW   = 12;
    localparam int unsigned MAXD = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, i_gnt, i_rvalid;
    logic [31:0]   i_addr, i_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [31:0]   d_addr, d_wdata, d_rdata;
    logic [3:0]    d_be;
    logic          m_en, m_we;
    logic [3:0]    m_be;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata = 32'h0;

    always #5 clk = ~clk;

    rv_mem_arbiter #(.AW(AW), .MAX_DSTREAK(MAXD)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    // Behavioural SRAM with 1-cycle read latency; read data holds when not enabled.
    logic [31:0] sram [DEPTH];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) begin
                for (int b = 0; b < 4; b++) if (m_be[b]) sram[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
            end else begin
                m_rdata <= sram[m_addr];
            end
        end
    end

    typedef struct {
        logic        valid;
        logic        own;
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] ref_mem [DEPTH];
    int          streak_m;
    logic [31:0] sram_out_m, ihold_m, dhold_m;
    int          tests_run, tests_failed;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic ireq, input logic [31:0] iaddr,
                        input logic dreq, input logic dwe, input logic [31:0] daddr,
                        input logic [3:0] dbe, input logic [31:0] dwd, output logic dg_obs);
        resp_t e, n;
        logic exp_iv, exp_dv, gi, gd, oor, exp_men;
        logic [31:0] exp_ird, exp_drd;
        logic [AW-1:0] dword;
        rst = r; i_req = ireq; i_addr = iaddr;
        d_req = dreq; d_we = dwe; d_addr = daddr; d_be = dbe; d_wdata = dwd;
        #1;
        // Response from the previous cycle's grant.
        if (exp_q.size() == 0) begin
            check_val("queue_underflow", 32'd0, 32'd1);
            e = '{valid: 1'b0, own: 1'b0, err: 1'b0, data: 32'h0};
        end else begin
            e = exp_q.pop_front();
        end
        exp_iv  = !r && e.valid && e.own == OWN_I;
        exp_dv  = !r && e.valid && e.own == OWN_D;
        exp_ird = r ? 32'h0 : (exp_iv ? e.data : ihold_m);
        exp_drd = r ? 32'h0 : (exp_dv ? (e.err ? 32'h0 : e.data) : dhold_m);
        ihold_m = exp_ird;
        dhold_m = exp_drd;
        check_val("i_rvalid", {31'h0, i_rvalid}, {31'h0, exp_iv});
        check_val("d_rvalid", {31'h0, d_rvalid}, {31'h0, exp_dv});
        check_val("d_err", {31'h0, d_err}, {31'h0, exp_dv && e.err});
        check_val("i_rdata", i_rdata, exp_ird);
        check_val("d_rdata", d_rdata, exp_drd);
        // Grant model.
        gi = 1'b0; gd = 1'b0;
        if (!r) begin
            if (dreq && (!ireq || streak_m < int'(MAXD))) gd = 1'b1;
            else if (ireq) gi = 1'b1;
        end
        oor   = |daddr[31:AW+2];
        dword = daddr[AW+1:2];
        exp_men = gi || (gd && !oor);
        check_val("i_gnt", {31'h0, i_gnt}, {31'h0, gi});
        check_val("d_gnt", {31'h0, d_gnt}, {31'h0, gd});
        check_val("m_en", {31'h0, m_en}, {31'h0, exp_men});
        if (gi) begin
            check_val("m_addr_i", {20'h0, m_addr}, {20'h0, iaddr[AW-1:0]});
            check_val("m_we_i", {31'h0, m_we}, 32'h0);
            check_val("m_be_i", {28'h0, m_be}, 32'hF);
        end else if (gd && !oor) begin
            check_val("m_addr_d", {20'h0, m_addr}, {20'h0, dword});
            check_val("m_we_d", {31'h0, m_we}, {31'h0, dwe});
            check_val("m_be_d", {28'h0, m_be}, {28'h0, dwe ? dbe : 4'hF});
            if (dwe) check_val("m_wdata", m_wdata, dwd);
        end
        dg_obs = d_gnt;
        // Next-cycle expectation and reference memory update.
        n = '{valid: gi || gd, own: gd ? OWN_D : OWN_I, err: gd && oor, data: 32'h0};
        if (gi) begin
            sram_out_m = ref_mem[iaddr[AW-1:0]];
            n.data = sram_out_m;
        end else if (gd && !oor) begin
            if (dwe) begin
                n.data = sram_out_m;
                for (int b = 0; b < 4; b++) if (dbe[b]) ref_mem[dword][8*b +: 8] = dwd[8*b +: 8];
            end else begin
                sram_out_m = ref_mem[dword];
                n.data = sram_out_m;
            end
        end
        exp_q.push_back(n);
        if (r || !ireq || gi) streak_m = 0;
        else if (gd && streak_m < int'(MAXD)) streak_m++;
        @(posedge clk);
        #1;
    endtask

    logic        dg;
    logic [11:0] seq;

    initial begin
        tests_run = 0; tests_failed = 0;
        streak_m = 0; sram_out_m = 32'h0; ihold_m = 32'h0; dhold_m = 32'h0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            sram[k]    = 32'hC0DE_0000 | k;
            ref_mem[k] = 32'hC0DE_0000 | k;
        end
        sram[5]    = 32'h0050_0093;
        ref_mem[5] = 32'h0050_0093;
        exp_q.push_back('{valid: 1'b0, own: 1'b0, err: 1'b0, data: 32'h0});

        // Reset and first idle cycle after it.
        step(1, 0, 0, 0, 0, 0, 0, 0, dg);
        step(1, 0, 0, 0, 0, 0, 0, 0, dg);
        step(0, 0, 0, 0, 0, 0, 0, 0, dg);

        // Single fetch through the aliased base address.
        step(0, 1, MEM_BASE | 32'h5, 0, 0, 0, 0, 0, dg);
        step(0, 0, 0, 0, 0, 0, 0, 0, dg);
        check_val("fetch_word5", i_rdata, 32'h0050_0093);

        // Byte-lane write then read-back of the same word.
        step(0, 0, 0, 1, 1, 32'h10, 4'b0100, 32'h00AB_0000, dg);
        step(0, 0, 0, 1, 0, 32'h10, 4'h0, 32'h0, dg);
        step(0, 0, 0, 0, 0, 0, 0, 0, dg);
        check_val("rd_byte2", {24'h0, d_rdata[23:16]}, 32'hAB);

        // Contention: data wins four times, then fetch.
        seq = '0;
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 32'h20 + k, 1, 0, 32'h100 + 4 * k, 0, 0, dg);
            seq[11-k] = dg;
        end
        check_val("grant_seq", {20'h0, seq}, {20'h0, 12'b1111_0111_1011});
        step(0, 0, 0, 0, 0, 0, 0, 0, dg);

        // Out-of-range read and write.
        step(0, 0, 0, 1, 0, 32'h0000_4000, 0, 0, dg);
        step(0, 0, 0, 1, 1, 32'h0001_0008, 4'hF, 32'hDEAD_BEEF, dg);
        step(0, 0, 0, 0, 0, 0, 0, 0, dg);

        // Back-to-back fetch then data read.
        step(0, 1, 32'h5, 0, 0, 0, 0, 0, dg);
        step(0, 0, 0, 1, 0, 32'h10, 0, 0, dg);
        step(0, 0, 0, 0, 0, 0, 0, 0, dg);

        // Build a streak, reset during a fetch request, then contention restarts from zero.
        step(0, 1, 32'h7, 1, 0, 32'h40, 0, 0, dg);
        step(0, 1, 32'h7, 1, 0, 32'h44, 0, 0, dg);
        step(1, 1, 32'h9, 0, 0, 0, 0, 0, dg);
        for (int k = 0; k < 6; k++) step(0, 1, 32'h30 + k, 1, 0, 32'h200 + 4 * k, 0, 0, dg);
        step(0, 0, 0, 0, 0, 0, 0, 0, dg);

        // Random traffic including dropped requests and occasional out-of-range accesses.
        for (int k = 0; k < 60; k++) begin
            logic [31:0] ra;
            ra = {22'h0, 10'($urandom_range(0, 1023))};
            if ($urandom_range(0, 7) == 0) ra = ra | 32'h0100_0000;
            step(0, 1'($urandom_range(0, 1)), {20'h0, 12'($urandom_range(0, 63))},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
                 4'($urandom_range(0, 15)), $urandom, dg);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, dg);
        step(0, 0, 0, 0, 0, 0, 0, 0, dg);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
